// File: rtl/md_pkg.sv
// Shared types and op-class predicates for the multiply/divide unit.
package md_pkg;

    typedef enum logic [3:0] {
        OpMult  = 4'd0,
        OpMultu = 4'd1,
        OpDiv   = 4'd2,
        OpDivu  = 4'd3,
        OpMadd  = 4'd4,
        OpMaddu = 4'd5,
        OpMsub  = 4'd6,
        OpMsubu = 4'd7,
        OpMthi  = 4'd8,
        OpMtlo  = 4'd9
    } md_op_t;

    // Multiplies and multiply-accumulates share the multiply latency.
    function automatic logic is_mult_op(md_op_t op);
        return op inside {OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu};
    endfunction

    function automatic logic is_div_op(md_op_t op);
        return op inside {OpDiv, OpDivu};
    endfunction

    function automatic logic is_mt_op(md_op_t op);
        return op inside {OpMthi, OpMtlo};
    endfunction

endpackage

// File: rtl/md_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_latency_ctr.sv
// Loadable down-counter timing a multi-cycle operation; last_o marks its final cycle.
module md_latency_ctr #(
    parameter int unsigned CTR_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [CTR_WIDTH-1:0] value_i,
    input  logic                 clear_i,
    output logic                 last_o
);
    logic [CTR_WIDTH-1:0] cnt_q, cnt_d;

    // Clear beats load; a load on the final cycle restarts for a back-to-back op.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CTR_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CTR_WIDTH'(1));
endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO; the result is computed at accept and
// held pending until the latency counter expires.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    md_if.slave  bus
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CtrW      = $clog2(MaxCycles + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               skip_q, skip_d, busy_q, busy_d, done_q, done_d;
    logic               ctr_load, ctr_clear, ctr_last;
    logic [CtrW-1:0]    ctr_value;
    logic               accept, op_signed;
    md_op_t             op;
    logic [2*WIDTH-1:0] acc, ext_a, ext_b, prod;
    logic [WIDTH-1:0]   divisor, quo, rem;

    assign op        = md_op_t'(bus.op);
    assign op_signed = op inside {OpMult, OpDiv, OpMadd, OpMsub};

    // Arithmetic on the live operands; divide by zero uses a dummy divisor (result unused).
    always_comb begin
        ext_a   = op_signed ? {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a}
                            : {{WIDTH{1'b0}}, bus.src_a};
        ext_b   = op_signed ? {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b}
                            : {{WIDTH{1'b0}}, bus.src_b};
        prod    = ext_a * ext_b;
        divisor = (bus.src_b == '0) ? WIDTH'(1) : bus.src_b;
        if (op == OpDiv) begin
            if (bus.src_a == {1'b1, {(WIDTH-1){1'b0}}} && bus.src_b == '1) begin
                quo = bus.src_a;
                rem = '0;
            end else begin
                quo = WIDTH'($signed(bus.src_a) / $signed(divisor));
                rem = WIDTH'($signed(bus.src_a) % $signed(divisor));
            end
        end else begin
            quo = bus.src_a / divisor;
            rem = bus.src_a % divisor;
        end
    end

    // FSM next state, commit and accept; an accept on the commit cycle sees the committed HI:LO.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        res_d     = res_q;
        skip_d    = skip_q;
        done_d    = 1'b0;
        ctr_load  = 1'b0;
        ctr_clear = 1'b0;
        ctr_value = '0;
        accept    = 1'b0;
        acc       = '0;

        unique case (state_q)
            StIdle: accept = bus.start & ~bus.flush;
            StRun: begin
                if (bus.flush) begin
                    state_d   = StIdle;
                    ctr_clear = 1'b1;
                end else if (ctr_last) begin
                    if (!skip_q) {hi_d, lo_d} = res_q;
                    done_d  = 1'b1;
                    state_d = StIdle;
                    accept  = bus.start;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            acc = {hi_d, lo_d};
            if (is_mt_op(op)) begin
                if (op == OpMthi) hi_d = bus.src_a;
                else              lo_d = bus.src_a;
            end else if (is_mult_op(op) || is_div_op(op)) begin
                if (is_div_op(op))                      res_d = {rem, quo};
                else if (op inside {OpMadd, OpMaddu})   res_d = acc + prod;
                else if (op inside {OpMsub, OpMsubu})   res_d = acc - prod;
                else                                    res_d = prod;
                skip_d    = is_div_op(op) && (bus.src_b == '0);
                ctr_load  = 1'b1;
                ctr_value = is_div_op(op) ? CtrW'(DIV_CYCLES) : CtrW'(MULT_CYCLES);
                state_d   = StRun;
            end
        end

        busy_d = (state_d == StRun);
    end

    // State and architectural registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            skip_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            skip_q  <= skip_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    md_latency_ctr #(
        .CTR_WIDTH(CtrW)
    ) u_ctr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (ctr_load),
        .value_i(ctr_value),
        .clear_i(ctr_clear),
        .last_o (ctr_last)
    );

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Randomised self-checking bench for md_unit: 32-bit default instance plus a 16-bit,
// short-latency instance, both checked against an arithmetic reference model.
module tb_md_unit;
    logic clk;
    logic rst_n;

    md_if #(.WIDTH(32)) i32 ();
    md_if #(.WIDTH(16)) i16 ();

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut32 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (i32)
    );

    md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut16 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (i16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] m_hi, m_lo;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: architectural effect of one op on HI:LO (32-bit).
    function automatic void model_exec(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        logic [63:0] acc, prod;
        longint sa, sb;
        acc  = {m_hi, m_lo};
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        prod = (op == 0 || op == 4 || op == 6) ? 64'(sa * sb) : {32'd0, a} * {32'd0, b};
        case (op)
            0, 1: {m_hi, m_lo} = prod;
            4, 5: {m_hi, m_lo} = acc + prod;
            6, 7: {m_hi, m_lo} = acc - prod;
            2: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a;
                    m_hi = 32'd0;
                end else begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
            end
            3: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            8: m_hi = a;
            9: m_lo = a;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op on the 32-bit unit from an idle negedge and check every cycle to done.
    // poke_at >= 0 injects an MTHI start in that busy cycle, which must be ignored.
    task automatic op32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at);
        int n;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        i32.op = op; i32.src_a = a; i32.src_b = b; i32.start = 1'b1;
        @(negedge clk);
        i32.start = 1'b0;
        model_exec(op, a, b);
        if (op <= 4'd7) begin
            n = (op == 2 || op == 3) ? 10 : 5;
            for (int k = 0; k < n; k++) begin
                check_eq("busy_run", i32.busy, 1);
                check_eq("done_run", i32.done, 0);
                check_eq("hi_hold", i32.hi, old_hi);
                check_eq("lo_hold", i32.lo, old_lo);
                if (k == poke_at && k < n - 1) begin
                    i32.start = 1'b1; i32.op = 4'd8; i32.src_a = $urandom;
                end else begin
                    i32.start = 1'b0;
                end
                @(negedge clk);
            end
            i32.start = 1'b0;
            check_eq("busy_end", i32.busy, 0);
            check_eq("done_end", i32.done, 1);
            check_eq("hi_res", i32.hi, m_hi);
            check_eq("lo_res", i32.lo, m_lo);
            @(negedge clk);
            check_eq("done_pulse", i32.done, 0);
        end else begin
            check_eq("busy_mt", i32.busy, 0);
            check_eq("done_mt", i32.done, 0);
            check_eq("hi_mt", i32.hi, m_hi);
            check_eq("lo_mt", i32.lo, m_lo);
        end
    endtask

    // Single op on the 16-bit unit with explicit expected values.
    task automatic op16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int n, input logic [15:0] ehi, input logic [15:0] elo);
        i16.op = op; i16.src_a = a; i16.src_b = b; i16.start = 1'b1;
        @(negedge clk);
        i16.start = 1'b0;
        for (int k = 0; k < n; k++) begin
            check_eq("w16_busy", i16.busy, 1);
            @(negedge clk);
        end
        check_eq("w16_busy_end", i16.busy, 0);
        check_eq("w16_done", i16.done, 1);
        check_eq("w16_hi", i16.hi, ehi);
        check_eq("w16_lo", i16.lo, elo);
        @(negedge clk);
        check_eq("w16_done_pulse", i16.done, 0);
    endtask

    function automatic logic [31:0] prod16(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        if (op == 4'd0) return 32'(int'($signed(a)) * int'($signed(b)));
        return {16'd0, a} * {16'd0, b};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] old_hi, old_lo, prev;
    logic [15:0] a16, b16;
    logic [3:0]  o16;

    initial begin
        rst_n = 1'b0;
        i32.start = 0; i32.op = 0; i32.src_a = 0; i32.src_b = 0; i32.flush = 0;
        i16.start = 0; i16.op = 0; i16.src_a = 0; i16.src_b = 0; i16.flush = 0;
        m_hi = 0; m_lo = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", i32.busy, 0);
        check_eq("rst_done", i32.done, 0);
        check_eq("rst_hi", i32.hi, 0);
        check_eq("rst_lo", i32.lo, 0);
        check_eq("rst16_hilo", {i16.hi, i16.lo}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        op32(4'd0, -32'sd3, 32'd7, -1);
        check_eq("mult_hi", i32.hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", i32.lo, 32'hFFFF_FFEB);
        op32(4'd2, -32'sd7, 32'd2, -1);
        check_eq("div_lo", i32.lo, 32'hFFFF_FFFD);
        check_eq("div_hi", i32.hi, 32'hFFFF_FFFF);
        op32(4'd3, 32'h8000_0000, 32'd0, -1);
        check_eq("divz_lo", i32.lo, 32'hFFFF_FFFD);
        op32(4'd8, 32'd0, 32'd0, -1);
        op32(4'd9, 32'hFFFF_FFFF, 32'd0, -1);
        op32(4'd5, 32'd1, 32'd1, -1);
        check_eq("maddu_hilo", {i32.hi, i32.lo}, 64'h0000_0001_0000_0000);
        op32(4'd8, 32'd0, 32'd0, -1);
        op32(4'd9, 32'd0, 32'd0, -1);
        op32(4'd6, 32'd1, 32'd1, -1);
        check_eq("msub_hilo", {i32.hi, i32.lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        op32(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2);

        // Flush in the 3rd busy cycle.
        op32(4'd8, 32'h1111_2222, 32'd0, -1);
        old_hi = m_hi; old_lo = m_lo;
        i32.op = 4'd0; i32.src_a = 32'd9; i32.src_b = 32'd9; i32.start = 1'b1;
        @(negedge clk);
        i32.start = 1'b0;
        repeat (2) @(negedge clk);
        i32.flush = 1'b1;
        @(negedge clk);
        i32.flush = 1'b0;
        check_eq("flush_busy", i32.busy, 0);
        for (int k = 0; k < 6; k++) begin
            check_eq("flush_nodone", i32.done, 0);
            check_eq("flush_hilo", {i32.hi, i32.lo}, {old_hi, old_lo});
            @(negedge clk);
        end
        // Start together with flush is dropped.
        i32.op = 4'd8; i32.src_a = 32'hDEAD_BEEF; i32.start = 1'b1; i32.flush = 1'b1;
        @(negedge clk);
        check_eq("flush_mt_hi", i32.hi, old_hi);
        i32.op = 4'd0;
        @(negedge clk);
        i32.start = 1'b0; i32.flush = 1'b0;
        check_eq("flush_start_busy", i32.busy, 0);
        repeat (6) @(negedge clk);
        check_eq("flush_start_done", i32.done, 0);
        check_eq("flush_start_hilo", {i32.hi, i32.lo}, {old_hi, old_lo});

        // Asynchronous reset in the 4th DIV cycle.
        i32.op = 4'd2; i32.src_a = 32'd100; i32.src_b = 32'd7; i32.start = 1'b1;
        @(negedge clk);
        i32.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", i32.busy, 0);
        check_eq("arst_done", i32.done, 0);
        check_eq("arst_hi", i32.hi, 0);
        check_eq("arst_lo", i32.lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = 0; m_lo = 0;
        @(negedge clk);
        check_eq("arst_idle", i32.busy, 0);
        op32(4'd0, 32'd2, 32'd3, -1);
        check_eq("arst_mult_lo", i32.lo, 32'd6);

        // Random ops, including reserved codes and ignored starts while busy.
        for (int i = 0; i < 40; i++) begin
            op32(4'($urandom_range(0, 15)), pick(), pick(), (i % 4 == 0) ? 2 : -1);
        end

        // 16-bit, short-latency instance.
        op16(4'd2, 16'h8000, 16'hFFFF, 3, 16'h0000, 16'h8000);
        op16(4'd3, 16'd100, 16'd7, 3, 16'd2, 16'd14);
        op16(4'd1, 16'hFFFF, 16'h0002, 1, 16'h0001, 16'hFFFE);
        for (int i = 0; i < 8; i++) begin
            o16 = 4'($urandom_range(0, 1));
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            i16.op = o16; i16.src_a = a16; i16.src_b = b16; i16.start = 1'b1;
            @(negedge clk);
            check_eq("b2b_busy", i16.busy, 1);
            if (i > 0) begin
                check_eq("b2b_done", i16.done, 1);
                check_eq("b2b_hilo", {i16.hi, i16.lo}, prev);
            end else begin
                check_eq("b2b_first_done", i16.done, 0);
            end
            prev = prod16(o16, a16, b16);
        end
        i16.start = 1'b0;
        @(negedge clk);
        check_eq("b2b_busy_end", i16.busy, 0);
        check_eq("b2b_done_end", i16.done, 1);
        check_eq("b2b_hilo_end", {i16.hi, i16.lo}, prev);
        @(negedge clk);
        check_eq("b2b_done_pulse", i16.done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers. It sits beside the ALU in the EX stage and drives the `busy` signal that the hazard unit turns into a pipeline stall. Compared with the fixed multiplier/divider it generalises the datapath width and per-operation latency. It adds multiply-accumulate/subtract modes and a flush input that aborts an in-flight operation.

## Interface
- `WIDTH`, 32: operand and HI/LO width; product/accumulator width is 2*WIDTH.
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU/MADD*/MSUB*. Must be ≥1.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU. Must be ≥1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch the operation in `op`; sampled on the rising edge.
- `op`  in  4  `md_op_t` operation code.
- `src_a`  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- `src_b`  in  WIDTH  rt operand (divisor / multiplier).
- `flush`  in  1  abort the in-flight operation; discard any same-cycle `start`.
- `busy`  out  1  registered; high while an operation is pending.
- `done`  out  1  registered one-cycle pulse in the first cycle new HI/LO values are visible.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
Op codes:
- 0 MULT, 1 MULTU: HI:LO = a*b, signed / unsigned.
- 2 DIV, 3 DIVU: LO = a/b, HI = a%b. Signed division truncates toward zero; the remainder takes the dividend's sign.
- 4 MADD, 5 MADDU: HI:LO += a*b, signed / unsigned.
- 6 MSUB, 7 MSUBU: HI:LO -= a*b, signed / unsigned.
- 8 MTHI, 9 MTLO: write HI or LO.
- 10–15: reserved; `start` is ignored.

Rules:
- Accepting `start` when idle: operands, op and the full result are captured into pending registers. HI:LO is not changed until commit.
- Accumulate ops use the HI:LO value present at accept. No other writer can change HI:LO while `busy` is high.
- All 2*WIDTH arithmetic wraps modulo 2^(2*WIDTH).
- Divide by zero: the operation runs its full latency, then commits nothing. HI/LO stay unchanged and `done` still pulses.
- Signed overflow (a = -2^(WIDTH-1), b = -1): LO = -2^(WIDTH-1), HI = 0.
- MTHI/MTLO when idle: the register is written at the accepting edge. `busy` is not asserted and `done` is not pulsed.
- `start` while `busy` is high is ignored. The hazard unit guarantees this does not happen; the bench checks that it is ignored.
- `flush` while busy: the pending result is discarded, HI/LO are unchanged, `busy` drops at the next edge and no `done` is produced.
- `flush` with `start` in the same cycle: `start` is dropped, including MTHI/MTLO.
- Reset (asynchronous, any time, including mid-operation): `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, FSM=IDLE.

FSM:
- IDLE → RUN on an accepted mult/div. The counter loads the op latency.
- RUN: the counter decrements each cycle. Counter==1 → COMMIT edge: HI/LO written, `done` set, return to IDLE.
- RUN → IDLE on `flush`.

## Timing
- Start accepted at edge E0.
- `busy` is high for exactly N cycles after E0, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO update and `done` rises at edge E0+N; `busy` falls at the same edge.
- A new `start` may be accepted at E0+N. Back-to-back throughput is one op per N cycles.
- MTHI/MTLO: value visible one cycle after the accepting edge (edge E0).
- The hazard unit must stall EX on (`busy` | (`start` & mult/div op)). `busy` is registered and does not cover the start cycle.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

## Structure
- Shared package `md_pkg`:
  - `md_op_t` enum with the encodings above.
  - Helper predicates `is_mult_op`, `is_div_op`, `is_mt_op`.
- Sub-module `md_latency_ctr`: loadable down-counter with `load`, `value`, `clear`, `last` outputs. It is reused by a future iterative divider.

## Test plan
- MULT, defaults: a=-3, b=7 at E0. `busy` is high for 5 cycles; at E0+5, HI=0xFFFFFFFF, LO=0xFFFFFFEB and `done`=1 for one cycle.
- DIV: a=-7, b=2. After 10 cycles, LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1). Then DIVU with a=0x80000000, b=0 gives `done` with HI/LO unchanged.
- MADDU: with HI:LO=0x00000000_FFFFFFFF preset via MTLO, a=1, b=1 gives HI=1, LO=0. MSUB a=1, b=1 from HI:LO=0 gives HI=LO=0xFFFFFFFF.
- `flush` asserted in the 3rd busy cycle of MULT: `busy` is 0 the next cycle, no `done`, HI/LO keep their old values. A `start` with `flush` in the same cycle is dropped.
- `reset` pulled low mid-DIV (cycle 4): `busy`, `done`, `hi`, `lo` go to 0 immediately. After release, a MULT 2*3 gives LO=6 after 5 cycles.
- Parameter sweep WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3:
  - 0x8000 / 0xFFFF gives LO=0x8000, HI=0.
  - Back-to-back MULTs accepted every cycle; `busy` is high for exactly 1 cycle each.
